// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op codes, default latencies, FSM state type.
package e_mdu_pkg;

  // 4-bit op codes, also used by the controller decoder
  localparam logic [3:0] MDU_OP_NONE  = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd8;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // True for the ops that open a busy window
  function automatic logic mdu_is_muldiv(input logic [3:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational multiply/divide datapath: produces the {hi,lo} temp value
// for mult/multu/div/divu and flags divide-by-zero.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_res,
  output logic        o_dbz
);

  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic        w_ovf;

  assign w_a_sx = {{32{i_a[31]}}, i_a};
  assign w_b_sx = {{32{i_b[31]}}, i_b};
  assign w_a_zx = {32'd0, i_a};
  assign w_b_zx = {32'd0, i_b};
  // Most-negative / -1 overflows the quotient; pin the architectural answer
  assign w_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Select the result for the current op; low 64 bits of the extended
  // product are correct for both signed and unsigned multiply.
  always_comb begin
    o_res = 64'd0;
    o_dbz = 1'b0;
    case (i_op)
      MDU_OP_MULT:  o_res = w_a_sx * w_b_sx;
      MDU_OP_MULTU: o_res = w_a_zx * w_b_zx;
      MDU_OP_DIV: begin
        if (i_b == 32'd0)  o_dbz = 1'b1;
        else if (w_ovf)    o_res = {32'd0, 32'h8000_0000};
        else begin
          o_res[31:0]  = $signed(i_a) / $signed(i_b);
          o_res[63:32] = $signed(i_a) % $signed(i_b);
        end
      end
      MDU_OP_DIVU: begin
        if (i_b == 32'd0)  o_dbz = 1'b1;
        else begin
          o_res[31:0]  = i_a / i_b;
          o_res[63:32] = i_a % i_b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: HI/LO registers, fixed-latency busy
// window for mult/div, mfhi/mflo read port and the D-stage stall source.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        busy,
  output logic        mdu_stall_src,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] result
);

  mdu_state_e  r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic [63:0] r_temp;
  logic        r_dbz;
  logic [31:0] r_hi, r_lo;

  logic [63:0] w_calc;
  logic        w_dbz;
  logic        w_take;      // idle, valid and not squashed by an exception
  logic        w_accept;    // mult/div accepted this edge
  logic        w_commit;    // counter going 1->0 this edge
  logic        w_mthi, w_mtlo;

  mdu_calc u_calc (
    .i_op  (op),
    .i_a   (A),
    .i_b   (B),
    .o_res (w_calc),
    .o_dbz (w_dbz)
  );

  assign w_take = (r_state == MDU_IDLE) && start && !req;
  assign w_mthi = w_take && (op == MDU_OP_MTHI);
  assign w_mtlo = w_take && (op == MDU_OP_MTLO);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= MDU_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and accept/commit strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (w_take && mdu_is_muldiv(op)) begin
          w_accept    = 1'b1;
          w_state_nxt = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (r_cnt == 32'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = MDU_IDLE;
        end
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end

  // Latency counter: load on accept, count down while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cnt <= 32'd0;
    else if (w_accept)
      r_cnt <= ((op == MDU_OP_MULT) || (op == MDU_OP_MULTU)) ?
               32'(MULT_CYCLES) : 32'(DIV_CYCLES);
    else if (r_state == MDU_BUSY)
      r_cnt <= r_cnt - 32'd1;
  end

  // Capture the computed result at accept; it is held until commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_temp <= 64'd0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_temp <= w_calc;
      r_dbz  <= w_dbz;
    end
  end

  // Architectural HI/LO: commit from temp (skipped on divide-by-zero) or mthi/mtlo
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_dbz) begin
        r_hi <= r_temp[63:32];
        r_lo <= r_temp[31:0];
      end
    end else begin
      if (w_mthi) r_hi <= A;
      if (w_mtlo) r_lo <= A;
    end
  end

  assign busy          = (r_state == MDU_BUSY);
  assign mdu_stall_src = (start && mdu_is_muldiv(op) && !req) || busy;
  assign HI            = r_hi;
  assign LO            = r_lo;
  // No bypass: mfhi/mflo in the busy window are held off by the stall
  assign result        = (op == MDU_OP_MFHI) ? r_hi :
                         (op == MDU_OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the pipelined MIPS core.
- Owns the HI/LO registers and executes mult/multu/div/divu with a fixed-latency busy window.
- Serves mfhi/mflo, whose result travels E->M->W into the register-file write port.
- Its busy/start outputs drive the D-stage stall logic.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  MDU instruction valid in E this cycle
- op  input  4  operation code (see Behaviour)
- A  input  32  rs operand, already forwarded
- B  input  32  rt operand, already forwarded
- req  input  1  exception/interrupt taken this cycle; suppresses any new op
- busy  output  1  multi-cycle operation in progress
- mdu_stall_src  output  1  start & (op is MULT/MULTU/DIV/DIVU) & ~req, or busy; stall source for D-stage MDU instructions
- HI  output  32  architectural HI
- LO  output  32  architectural LO
- result  output  32  HI when op==MFHI, LO when op==MFLO, else 0; combinational

Behaviour:
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9-15 behave as NONE.
- Reset (reset==0, async):
  - HI, LO, busy, internal counter and temp registers all cleared to 0 immediately.
  - Any in-flight operation is discarded.
- Idle state (busy=0). An op is accepted at a rising edge when start=1 and req=0:
  - MULT: temp {HI,LO} = signed A*B (64-bit). Counter loads MULT_CYCLES, busy=1.
  - MULTU: as MULT, but unsigned.
  - DIV: temp LO = A/B, temp HI = A%B. Signed, truncates toward zero; remainder takes the sign of A. Counter loads DIV_CYCLES, busy=1.
  - DIVU: as DIV, but unsigned.
  - MTHI: HI <= A at that edge, no busy.
  - MTLO: LO <= A at that edge, no busy.
  - MFHI, MFLO, NONE: no state change.
- Busy state:
  - Counter decrements each edge.
  - At the edge where the counter goes 1->0, HI/LO <= temp and busy drops.
  - busy is therefore high for exactly N cycles after the accept edge.
  - HI/LO hold their old values throughout the busy window.
- Start while busy: any op with start=1 is ignored entirely, including MTHI/MTLO (stall logic guarantees this never happens architecturally). MFHI/MFLO still return the current (old) HI/LO.
- req=1: blocks acceptance of every op in that cycle. It does NOT cancel an already-running operation; that operation commits normally.
- Divide by zero (B==0, DIV or DIVU): busy window runs full DIV_CYCLES, HI/LO unchanged at commit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Back-to-back ops: a new op may be accepted on the edge immediately after busy falls (busy sampled 0).
- result has no internal bypass: mfhi issued while busy is prevented by the stall, not by forwarding.

Decomposition:
- Shared header/package holds:
  - MDU op-code constants (4-bit), shared with the controller decoder.
  - MULT_CYCLES/DIV_CYCLES defaults.
- One combinational sub-module, mdu_calc: takes op, A, B and returns the 64-bit {hi,lo} temp plus a div_by_zero flag.
- e_mdu keeps the counter, busy FSM (IDLE/BUSY) and HI/LO registers.

Test Plan:
- Reset then MULT A=0xFFFFFFFE (-2), B=3 -> busy high 5 cycles; after commit HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFHI/MFLO results match.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001; HI/LO read old values on every cycle of the busy window.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
- MTHI A=0x12345678 with req=1 -> HI unchanged. Same with req=0 -> HI=0x12345678 next edge, busy stays 0. MTLO issued at cycle 2 of a running MULT -> ignored.
- DIV started, then reset pulled low at cycle 4 -> HI=LO=0, busy=0 immediately (before next clk edge). After release, MFLO returns 0.
- MULT accepted, then req=1 at cycle 2 -> operation still commits at cycle 5. A new DIV presented on the cycle busy falls is accepted, and busy re-rises for 10 cycles.
